// File: rtl/ntt_sched_pkg.sv
// ntt_sched_pkg -- shared types and width helpers for the NTT stage scheduler.
//   state_t       : scheduler FSM states (IDLE, ISSUE, DRAIN, FIN)
//   DEF_LOGN      : default log2 of transform size
//   DEF_PIPE_LAT  : default read-to-write-back latency
//   addr_w()      : address width for a given LOGN
//   stage_w()     : stage index width for a given LOGN
//   drain_w()     : drain counter width for a given PIPE_LAT
package ntt_sched_pkg;

  localparam int DEF_LOGN     = 8;
  localparam int DEF_PIPE_LAT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  // Addresses index an N-entry memory, N = 2^logn.
  function automatic int addr_w(input int logn);
    return logn;
  endfunction

  function automatic int stage_w(input int logn);
    return (logn < 2) ? 1 : $clog2(logn);
  endfunction

  // Counter runs 0..lat-1; a latency of 1 still needs one bit.
  function automatic int drain_w(input int lat);
    return (lat < 2) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/ntt_sched_delay.sv
// ntt_sched_delay -- DEPTH-deep shift register carrying the issue strobe and
// the two operand addresses forward to the write-back side.
//   clk, reset             : clock, synchronous active-high reset
//   in_valid, in_addr0/1   : issue strobe and addresses entering the pipe
//   out_valid, out_addr0/1 : the same values DEPTH cycles later
// Addresses of empty slots are carried as 0, so the outputs read 0 whenever
// out_valid is low.
module ntt_sched_delay #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_addr0,
  input  logic [W-1:0] in_addr1,
  output logic         out_valid,
  output logic [W-1:0] out_addr0,
  output logic [W-1:0] out_addr1
);

  logic [DEPTH-1:0] vld_q;
  logic [W-1:0]     a0_q [DEPTH];
  logic [W-1:0]     a1_q [DEPTH];

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its neighbour's pre-edge value and the line shifts by exactly one.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      // NOTE: the address stages are reset too (not just the valid bits)
      // so write addresses read 0 immediately after reset.
      for (int i = 0; i < DEPTH; i++) begin
        a0_q[i] <= '0;
        a1_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= in_valid;
      a0_q[0]  <= in_valid ? in_addr0 : '0;
      a1_q[0]  <= in_valid ? in_addr1 : '0;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        a0_q[i]  <= a0_q[i-1];
        a1_q[i]  <= a1_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_addr0 = a0_q[DEPTH-1];
  assign out_addr1 = a1_q[DEPTH-1];

endmodule

// File: rtl/ntt_stage_sched.sv
// ntt_stage_sched -- address/strobe scheduler for an in-place forward NTT.
// Walks LOGN stages; each stage issues N/2 butterflies (one per cycle), then
// drains for PIPE_LAT cycles so the last write-back of a stage lands before
// the first read of the next.
//   clk, reset          : clock, synchronous active-high reset
//   start               : begin a transform (sampled only in IDLE)
//   stall               : issue hold (present only with NTT_STALL_EN)
//   busy, done          : busy through ISSUE/DRAIN; done pulses in FIN
//   rd_en, rd_addr0/1   : butterfly issue strobe and operand addresses
//   tw_addr             : twiddle ROM address (bit-reversed table order)
//   wr_en, wr_addr0/1   : issue strobe/addresses delayed by PIPE_LAT
//   stage               : current stage index
// Optional feature macro: NTT_STALL_EN (adds the stall input).
module ntt_stage_sched
  import ntt_sched_pkg::*;
#(
  parameter int LOGN     = DEF_LOGN,
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
`ifdef NTT_STALL_EN
  input  logic                     stall,
`endif
  output logic                     busy,
  output logic                     done,
  output logic                     rd_en,
  output logic [addr_w(LOGN)-1:0]  rd_addr0,
  output logic [addr_w(LOGN)-1:0]  rd_addr1,
  output logic [addr_w(LOGN)-1:0]  tw_addr,
  output logic                     wr_en,
  output logic [addr_w(LOGN)-1:0]  wr_addr0,
  output logic [addr_w(LOGN)-1:0]  wr_addr1,
  output logic [stage_w(LOGN)-1:0] stage
);

  localparam int AW = addr_w(LOGN);
  localparam int SW = stage_w(LOGN);
  localparam int KW = LOGN - 1;            // k spans 0..N/2-1
  localparam int DW = drain_w(PIPE_LAT);

  localparam logic [KW-1:0] K_LAST = '1;
  localparam logic [SW-1:0] S_LAST = SW'(LOGN - 1);
  localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT - 1);

  state_t        state_q, state_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [KW-1:0] k_q, k_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          hold;

`ifdef NTT_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      stage_q <= '0;
      k_q     <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      k_q     <= k_d;
      dcnt_q  <= dcnt_d;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d = state_q;
    stage_d = stage_q;
    k_d     = k_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          stage_d = '0;
          k_d     = '0;
        end
      end
      ISSUE: begin
        // A stall freezes k and stage; nothing issues this cycle.
        if (!hold) begin
          if (k_q == K_LAST) begin
            state_d = DRAIN;
            k_d     = '0;
            dcnt_d  = '0;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      DRAIN: begin
        if (dcnt_q == D_LAST) begin
          dcnt_d = '0;
          if (stage_q == S_LAST) begin
            state_d = FIN;
          end else begin
            state_d = ISSUE;
            stage_d = stage_q + SW'(1);
          end
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      FIN: begin
        // Start is deliberately not looked at here.
        state_d = IDLE;
        stage_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Butterfly addressing for stage s, index k:
  //   h = 2^(LOGN-1-s), g = k >> (LOGN-1-s), j = k & (h-1)
  //   addr0 = 2hg + j, addr1 = addr0 + h, tw = 2^s + g
  // j < h and 2hg is a multiple of 2h, so the adds reduce to ORs and
  // never carry past bit LOGN-1.
  int            shamt;
  logic [AW-1:0] kx, h, g, j, a0, a1, tw;

  always_comb begin
    shamt = LOGN - 1 - int'(stage_q);
    kx    = AW'(k_q);
    h     = AW'(1) << shamt;
    g     = kx >> shamt;
    j     = kx & (h - AW'(1));
    a0    = (g << (shamt + 1)) | j;
    a1    = a0 | h;
    tw    = (AW'(1) << stage_q) | g;
  end

  assign rd_en    = (state_q == ISSUE) && !hold;
  assign rd_addr0 = rd_en ? a0 : '0;
  assign rd_addr1 = rd_en ? a1 : '0;
  assign tw_addr  = rd_en ? tw : '0;
  assign busy     = (state_q == ISSUE) || (state_q == DRAIN);
  assign done     = (state_q == FIN);
  assign stage    = stage_q;

  ntt_sched_delay #(
    .W     (AW),
    .DEPTH (PIPE_LAT)
  ) u_delay (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rd_en),
    .in_addr0  (rd_addr0),
    .in_addr1  (rd_addr1),
    .out_valid (wr_en),
    .out_addr0 (wr_addr0),
    .out_addr1 (wr_addr1)
  );

endmodule

// File: tb/tb_ntt_stage_sched.sv
// tb_ntt_stage_sched -- self-checking bench for ntt_stage_sched at LOGN=3,
// PIPE_LAT=4. The expected issue schedule is a constant table; expected
// write-backs are queued from it and popped as cycles go by.
module tb_ntt_stage_sched;

  localparam int LOGN     = 3;
  localparam int PIPE_LAT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
`ifdef NTT_STALL_EN
  logic       stall;
`endif
  logic       busy, done, rd_en, wr_en;
  logic [2:0] rd_addr0, rd_addr1, tw_addr, wr_addr0, wr_addr1;
  logic [1:0] stage;

  always #5 clk = ~clk;

  ntt_stage_sched #(
    .LOGN     (LOGN),
    .PIPE_LAT (PIPE_LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
`ifdef NTT_STALL_EN
    .stall    (stall),
`endif
    .busy     (busy),
    .done     (done),
    .rd_en    (rd_en),
    .rd_addr0 (rd_addr0),
    .rd_addr1 (rd_addr1),
    .tw_addr  (tw_addr),
    .wr_en    (wr_en),
    .wr_addr0 (wr_addr0),
    .wr_addr1 (wr_addr1),
    .stage    (stage)
  );

  typedef struct packed {
    int         t;
    logic [2:0] a0;
    logic [2:0] a1;
    logic [2:0] tw;
    logic [1:0] st;
  } issue_t;

  typedef struct packed {
    int         t;
    logic [2:0] a0;
    logic [2:0] a1;
  } wr_t;

  issue_t base_tbl [12];
  issue_t exp_q [$];
  wr_t    wr_q  [$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int cyc,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic issue_t mk(input int t, input int a0, input int a1,
                                input int tw, input int st);
    issue_t r;
    r.t  = t;
    r.a0 = 3'(a0);
    r.a1 = 3'(a1);
    r.tw = 3'(tw);
    r.st = 2'(st);
    return r;
  endfunction

  // Runs one transform window. Issues at t >= shift_from in the base table
  // are moved later by shift cycles (stall case); reset_t >= 0 asserts
  // reset in that cycle; done_t < 0 means no completion is expected.
  task automatic run_case(input int n_cyc, input int done_t, input int reset_t,
                          input int stall_lo, input int stall_hi,
                          input int shift_from, input int shift);
    issue_t e;
    wr_t    w;
    int     busy_end;
    logic   exp_rd, exp_wr;

    exp_q.delete();
    wr_q.delete();
    for (int i = 0; i < 12; i++) begin
      e = base_tbl[i];
      if (e.t >= shift_from) e.t = e.t + shift;
      if (reset_t < 0 || e.t <= reset_t) exp_q.push_back(e);
      if (reset_t < 0 || e.t + PIPE_LAT <= reset_t) begin
        w.t  = e.t + PIPE_LAT;
        w.a0 = e.a0;
        w.a1 = e.a1;
        wr_q.push_back(w);
      end
    end
    busy_end = (done_t > 0) ? done_t - 1 : reset_t;

    reset = 1'b1;
    start = 1'b0;
`ifdef NTT_STALL_EN
    stall = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;

    for (int c = 0; c < n_cyc; c++) begin
      start = (c == 0) || (c == 6) || (c == done_t);
      reset = (c == reset_t);
`ifdef NTT_STALL_EN
      stall = (c >= stall_lo) && (c <= stall_hi);
`endif
      #2;
      exp_rd = 1'b0;
      e      = '0;
      foreach (exp_q[i]) begin
        if (exp_q[i].t == c) begin
          exp_rd = 1'b1;
          e      = exp_q[i];
        end
      end
      check("rd_en", c, 32'(rd_en), 32'(exp_rd));
      if (exp_rd) begin
        check("rd_addr0/rd_addr1/tw_addr", c, 32'({rd_addr0, rd_addr1, tw_addr}),
              32'({e.a0, e.a1, e.tw}));
        check("stage", c, 32'(stage), 32'(e.st));
      end else if (reset_t >= 0 && c > reset_t) begin
        check("idle_addrs", c, 32'({rd_addr0, rd_addr1, tw_addr, wr_addr0, wr_addr1}), 32'(0));
        check("idle_stage", c, 32'(stage), 32'(0));
      end
      check("busy", c, 32'(busy), 32'(c >= 1 && c <= busy_end));
      check("done", c, 32'(done), 32'(c == done_t));

      exp_wr = (wr_q.size() > 0) && (wr_q[0].t == c);
      check("wr_en", c, 32'(wr_en), 32'(exp_wr));
      if (exp_wr) begin
        w = wr_q.pop_front();
        check("wr_addr0/wr_addr1", c, 32'({wr_addr0, wr_addr1}), 32'({w.a0, w.a1}));
      end else begin
        check("wr_addr_idle", c, 32'({wr_addr0, wr_addr1}), 32'(0));
      end

      @(posedge clk);
      #1;
    end
    check("writes_outstanding", n_cyc, 32'(wr_q.size()), 32'(0));
    start = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    // Stage 0: (k, k+4) tw 1; stage 1: pairs 2 apart, tw 2/3; stage 2:
    // adjacent pairs, tw 4..7.
    base_tbl[0]  = mk( 1, 0, 4, 1, 0);
    base_tbl[1]  = mk( 2, 1, 5, 1, 0);
    base_tbl[2]  = mk( 3, 2, 6, 1, 0);
    base_tbl[3]  = mk( 4, 3, 7, 1, 0);
    base_tbl[4]  = mk( 9, 0, 2, 2, 1);
    base_tbl[5]  = mk(10, 1, 3, 2, 1);
    base_tbl[6]  = mk(11, 4, 6, 3, 1);
    base_tbl[7]  = mk(12, 5, 7, 3, 1);
    base_tbl[8]  = mk(17, 0, 1, 4, 2);
    base_tbl[9]  = mk(18, 2, 3, 5, 2);
    base_tbl[10] = mk(19, 4, 5, 6, 2);
    base_tbl[11] = mk(20, 6, 7, 7, 2);

    reset = 1'b1;
    start = 1'b0;
`ifdef NTT_STALL_EN
    stall = 1'b0;
`endif

    // Full transform; starts at t=6 (busy) and t=25 (FIN) must be ignored,
    // and nothing issues again through t=39.
    run_case(40, 25, -1, -1, -2, 1000, 0);

    // Reset in cycle 10 aborts; nothing written back through t=20.
    run_case(21, -1, 10, -1, -2, 1000, 0);

`ifdef NTT_STALL_EN
    // Two stall cycles push every later issue, and done, by two.
    run_case(40, 27, -1, 2, 3, 2, 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
